// File: rtl/imem_loader_pkg.sv
// Shared constants, sizes and state encoding for the instruction-memory loader.
package imem_loader_pkg;

    localparam int XLEN          = 32;
    localparam int NWORDS        = 1024;
    localparam int LDR_HDR_BYTES = 4;
    localparam int CNT_W         = $clog2(LDR_HDR_BYTES);
    localparam int IDX_W         = $clog2(NWORDS) + 1;

    localparam logic [XLEN-1:0] NWORDS_MAX = XLEN'(NWORDS);

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_LEN   = 3'd1,
        LDR_DATA  = 3'd2,
        LDR_WRITE = 3'd3,
        LDR_CSUM  = 3'd4,
        LDR_FIN   = 3'd5
    } ldr_state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Shifts bytes into a little-endian 32-bit word; `word` and `full` already
// include the byte being accepted so the caller can act on it in the same cycle.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            byte_valid,
    input  logic [7:0]      byte_in,
    output logic [XLEN-1:0] word,
    output logic            full
);

    logic [XLEN-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default here infers a latch.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        word    = {byte_in, shreg_q[XLEN-1:8]};
        full    = byte_valid && (cnt_q == CNT_W'(LDR_HDR_BYTES - 1));
        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (byte_valid) begin
            shreg_d = word;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed image from a byte link into instruction memory.
// Optional trailing XOR checksum byte is enabled by IMEM_LOADER_CSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            we,
    output logic [XLEN-1:0] waddr,
    output logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            err
);

    ldr_state_e       state_q, state_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] idx_inc;
    logic             in_ready_q, in_ready_d;
    logic             we_q, we_d;
    logic [XLEN-1:0]  waddr_q, waddr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic             accept;
    logic             start_ok;
    logic             pk_valid;
    logic [XLEN-1:0]  pk_word;
    logic             pk_full;

    assign accept   = in_valid && in_ready_q;
    assign start_ok = start && ((state_q == LDR_IDLE) || (state_q == LDR_FIN));
    assign pk_valid = accept && ((state_q == LDR_LEN) || (state_q == LDR_DATA));
    assign idx_inc  = idx_q + IDX_W'(1);

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .byte_valid (pk_valid),
        .byte_in    (in_data),
        .word       (pk_word),
        .full       (pk_full)
    );

    // Registered outputs are computed from the next state, so they change on
    // the same edge as the state they describe.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d  = csum_q;
`endif

        case (state_q)
            LDR_IDLE, LDR_FIN: begin
                state_d = LDR_IDLE;
                if (start_ok) begin
                    state_d = LDR_LEN;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = '0;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LDR_LEN: begin
                if (pk_full) begin
                    if (pk_word == '0) begin
                        state_d = LDR_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (pk_word > NWORDS_MAX) begin
                        state_d = LDR_FIN;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LDR_DATA;
                        len_d   = pk_word[IDX_W-1:0];
                    end
                end
            end
            LDR_DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                end
`endif
                if (pk_full) begin
                    state_d = LDR_WRITE;
                    we_d    = 1'b1;
                    waddr_d = XLEN'({idx_q, 2'b00});
                    wdata_d = pk_word;
                end
            end
            LDR_WRITE: begin
                idx_d = idx_inc;
                if (idx_inc == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
                    state_d = LDR_CSUM;
`else
                    state_d = LDR_FIN;
                    busy_d  = 1'b0;
                    done_d  = !err_q;
`endif
                end else begin
                    state_d = LDR_DATA;
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            LDR_CSUM: begin
                if (accept) begin
                    state_d = LDR_FIN;
                    busy_d  = 1'b0;
                    if (in_data != csum_q) begin
                        err_d = 1'b1;
                    end else begin
                        done_d = !err_q;
                    end
                end
            end
`endif
            default: state_d = LDR_IDLE;
        endcase

        in_ready_d = (state_d == LDR_LEN) || (state_d == LDR_DATA) || (state_d == LDR_CSUM);
    end

    // NOTE: reset is asynchronous and clears every flop; there is no storage
    // array here, so nothing is left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LDR_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign in_ready = in_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
